ftdi_tx_scheduler: RTL



---
 rtl/ftdi_tx_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ftdi_tx_scheduler.sv
// ftdi_tx_scheduler: round-robin packet scheduler feeding one FTDI fast-serial byte transmitter
// Each granted packet is sent as a header byte 8'hA0|id followed by the requester's payload.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   req_valid/last   per-requester byte valid and end-of-packet marker
//   req_data         per-requester byte, requester i on bits [8i+7:8i]
//   req_ready        combinational per-requester byte accept
//   tx_ready         serializer can take a byte
//   tx_data/strobe   registered byte and one-cycle read strobe to the serializer
//   grant            one-hot current owner, zero when idle
//   pkt_done         pulse when a packet ends on its last byte
//   err_trunc        pulse when a packet is cut off (length limit or stall watchdog)
// Optional: define FTDI_SCHED_WATCHDOG_EN to abort packets stalled for TIMEOUT cycles.
module ftdi_tx_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int MAX_LEN = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 tx_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_strobe,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 pkt_done,
   output logic                 err_trunc
);
   localparam int CW = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_LEN);
   if (NUM_REQ < 1 || NUM_REQ > 4 || MAX_LEN < 1 || TIMEOUT < 1) begin : g_param_check
      $error("ftdi_tx_scheduler: parameter out of range");
   end
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
   state_t state, state_n;
   logic [NUM_REQ-1:0]   grant_n, rot;
   logic [2*NUM_REQ-1:0] dbl;
   logic [1:0]           ptr, ptr_n, nxt, sel;
   logic [CW-1:0]        cnt, cnt_n, cnt_inc;
   logic [7:0]           data_n, cur_data;
   logic                 strobe_n, done_n, trunc_n, issue_ok, cur_valid, cur_last, found;
`ifdef FTDI_SCHED_WATCHDOG_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall, stall_n;
`endif
   // A strobe cycle always blocks issue, so strobes can never be back to back.
   assign issue_ok  = tx_ready & ~tx_strobe;
   assign req_ready = (state == PAYLOAD && issue_ok) ? grant : '0;
   assign cur_valid = |(req_valid & grant);
   assign cur_last  = |(req_last & grant);
   // Rotate requests so bit 0 is the requester just after the last owner.
   assign nxt = (int'(ptr) == NUM_REQ - 1) ? 2'd0 : ptr + 2'd1;
   assign dbl = {req_valid, req_valid} >> nxt;
   assign rot = dbl[NUM_REQ-1:0];
   always_comb begin
      found = 1'b0;
      sel   = ptr;
      for (int k = 0; k < NUM_REQ; k++)
         if (!found && rot[k]) begin
            found = 1'b1;
            sel   = 2'((int'(nxt) + k) % NUM_REQ);
         end
   end
   always_comb begin
      cur_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         cur_data = cur_data | (grant[i] ? req_data[8*i +: 8] : 8'd0);
   end
   always_comb begin
      state_n  = state;
      grant_n  = grant;
      ptr_n    = ptr;
      cnt_n    = cnt;
      data_n   = tx_data;
      strobe_n = 1'b0;
      done_n   = 1'b0;
      trunc_n  = 1'b0;
      cnt_inc  = (cnt == MAXC) ? cnt : cnt + 1'b1;
      if (state == IDLE) begin
         if (found) begin
            grant_n = NUM_REQ'(1) << sel;
            ptr_n   = sel;
            state_n = HEADER;
         end
      end else if (state == HEADER) begin
         if (issue_ok) begin
            data_n   = 8'hA0 | {6'd0, ptr};
            strobe_n = 1'b1;
            cnt_n    = '0;
            state_n  = PAYLOAD;
         end
      end else if (state == PAYLOAD) begin
         if (issue_ok && cur_valid) begin
            data_n   = cur_data;
            strobe_n = 1'b1;
            cnt_n    = cnt_inc;
            if (cur_last) begin
               done_n  = 1'b1;
               grant_n = '0;
               state_n = IDLE;
            end else if (cnt_inc == MAXC) begin
               trunc_n = 1'b1;
               grant_n = '0;
               state_n = IDLE;
            end
         end
      end else begin
         grant_n = '0;
         state_n = IDLE;
      end
`ifdef FTDI_SCHED_WATCHDOG_EN
      stall_n = (state == IDLE || strobe_n) ? '0 : stall + 1'b1;
      if (state != IDLE && !strobe_n && stall_n == SW'(TIMEOUT)) begin
         trunc_n = 1'b1;
         grant_n = '0;
         state_n = IDLE;
      end
`endif
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         grant     <= '0;
         ptr       <= 2'(NUM_REQ - 1);
         cnt       <= '0;
         tx_data   <= '0;
         tx_strobe <= 1'b0;
         pkt_done  <= 1'b0;
         err_trunc <= 1'b0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         ptr       <= ptr_n;
         cnt       <= cnt_n;
         tx_data   <= data_n;
         tx_strobe <= strobe_n;
         pkt_done  <= done_n;
         err_trunc <= trunc_n;
      end
`ifdef FTDI_SCHED_WATCHDOG_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) stall <= '0;
      else stall <= stall_n;
`endif
endmodule
